ct_idu_is_aiq_lch_sel: RTL and testbench

Launch selector for one arithmetic issue queue (AIQ) in the IDU issue stage. It sits directly downstream of the per-entry launch-ready registers and consumes each entry's 3-bit launch-ready vector. It keeps an age matrix across all entries and selects, every cycle, the oldest entry that is valid, not frozen and has all needed sources ready. It then drives a registered one-hot launch grant to the register-read stage and tracks frozen (launched, not yet retired from the queue) entries until they are popped or cancelled.

---
 rtl/ct_idu_is_aiq_lch_sel.sv | 138 +++++++++++++
 tb/tb_ct_idu_is_aiq_lch_sel.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ct_idu_is_aiq_lch_sel.sv
// ct_idu_is_aiq_lch_sel
//
// Launch selector for one arithmetic issue queue. Every cycle it picks the
// oldest entry that is valid, not frozen and has all of its used sources
// ready. It registers a one-hot launch grant and freezes the granted entry
// until the entry is popped, cancelled or re-created.
//
// Ports
//   y_clk          queue clock, rising edge
//   cpurst         synchronous active-high reset
//   x_vld          entry valid
//   x_lch_rdy      per-entry launch-ready, entry i at [i*SRC +: SRC]
//   x_src_vld      per-entry source-used mask, same packing
//   create0_en     create port 0 fires
//   create0_entry  one-hot target of create port 0
//   create1_en     create port 1 fires (younger than port 0)
//   create1_entry  one-hot target of create port 1
//   lch_stall      downstream cannot take a launch this cycle
//   lch_pop        one-hot, frozen entry leaves the queue
//   lch_cancel     unfreeze every frozen entry
//   lch_vld        registered launch valid
//   lch_entry      registered one-hot launch entry (zero when idle)
//   frz            frozen-entry vector (register value)

module ct_idu_is_aiq_lch_sel #(
    parameter int ENTRY = 8,
    parameter int SRC   = 3
) (
    input  logic                   y_clk,
    input  logic                   cpurst,
    input  logic [ENTRY-1:0]       x_vld,
    input  logic [ENTRY*SRC-1:0]   x_lch_rdy,
    input  logic [ENTRY*SRC-1:0]   x_src_vld,
    input  logic                   create0_en,
    input  logic [ENTRY-1:0]       create0_entry,
    input  logic                   create1_en,
    input  logic [ENTRY-1:0]       create1_entry,
    input  logic                   lch_stall,
    input  logic [ENTRY-1:0]       lch_pop,
    input  logic                   lch_cancel,
    output logic                   lch_vld,
    output logic [ENTRY-1:0]       lch_entry,
    output logic [ENTRY-1:0]       frz
);

    // age[i][j] = 1 : entry i is older than entry j
    logic [ENTRY-1:0][ENTRY-1:0] age;
    logic [ENTRY-1:0][ENTRY-1:0] age_nxt;

    logic [ENTRY-1:0] c0_vec;
    logic [ENTRY-1:0] c1_vec;
    logic [ENTRY-1:0] cr_vec;
    logic [ENTRY-1:0] rdy;
    logic [ENTRY-1:0] older_rdy;
    logic [ENTRY-1:0] win;
    logic [ENTRY-1:0] grant;
    logic [ENTRY-1:0] frz_nxt;

    always_comb begin
        c0_vec = create0_en ? create0_entry : '0;
        c1_vec = create1_en ? create1_entry : '0;
        cr_vec = c0_vec | c1_vec;
    end

    // Unused sources count as ready.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < ENTRY; i++) begin
            rdy[i] = x_vld[i] & ~frz[i]
                   & (&(x_lch_rdy[i*SRC +: SRC] | ~x_src_vld[i*SRC +: SRC]));
        end
    end

    // An entry wins when no other ready entry is older than it.
    always_comb begin
        older_rdy = '0;
        for (int i = 0; i < ENTRY; i++) begin
            for (int j = 0; j < ENTRY; j++) begin
                older_rdy[i] = older_rdy[i] | (rdy[j] & age[j][i]);
            end
        end
        win   = rdy & ~older_rdy;
        grant = lch_stall ? '0 : win;
    end

    // Created entries become the youngest; port 1 is younger than port 0,
    // so row c0 keeps only the bit pointing at c1.
    always_comb begin
        age_nxt = age;
        for (int i = 0; i < ENTRY; i++) begin
            for (int j = 0; j < ENTRY; j++) begin
                if (i == j) begin
                    age_nxt[i][j] = 1'b0;
                end else if (c1_vec[i]) begin
                    age_nxt[i][j] = 1'b0;
                end else if (c0_vec[i]) begin
                    age_nxt[i][j] = c1_vec[j];
                end else if (cr_vec[j]) begin
                    age_nxt[i][j] = 1'b1;
                end else begin
                    age_nxt[i][j] = age[i][j];
                end
            end
        end
    end

    // Freeze priority: create > pop > new grant > cancel. Selection above
    // used the pre-cancel frz, so a grant alongside a cancel still sticks.
    always_comb begin
        frz_nxt = frz;
        for (int i = 0; i < ENTRY; i++) begin
            if (cr_vec[i]) begin
                frz_nxt[i] = 1'b0;
            end else if (lch_pop[i]) begin
                frz_nxt[i] = 1'b0;
            end else if (grant[i]) begin
                frz_nxt[i] = 1'b1;
            end else if (lch_cancel) begin
                frz_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge y_clk) begin
        if (cpurst) begin
            age       <= '0;
            frz       <= '0;
            lch_vld   <= 1'b0;
            lch_entry <= '0;
        end else begin
            age       <= age_nxt;
            frz       <= frz_nxt;
            lch_vld   <= |grant;
            lch_entry <= grant;
        end
    end

endmodule

// File: tb/tb_ct_idu_is_aiq_lch_sel.sv
module tb_ct_idu_is_aiq_lch_sel;

    localparam int ENTRY = 8;
    localparam int SRC   = 3;

    logic                 y_clk;
    logic                 cpurst;
    logic [ENTRY-1:0]     x_vld;
    logic [ENTRY*SRC-1:0] x_lch_rdy;
    logic [ENTRY*SRC-1:0] x_src_vld;
    logic                 create0_en;
    logic [ENTRY-1:0]     create0_entry;
    logic                 create1_en;
    logic [ENTRY-1:0]     create1_entry;
    logic                 lch_stall;
    logic [ENTRY-1:0]     lch_pop;
    logic                 lch_cancel;
    logic                 lch_vld;
    logic [ENTRY-1:0]     lch_entry;
    logic [ENTRY-1:0]     frz;

    ct_idu_is_aiq_lch_sel #(.ENTRY(ENTRY), .SRC(SRC)) dut (
        .y_clk         (y_clk),
        .cpurst        (cpurst),
        .x_vld         (x_vld),
        .x_lch_rdy     (x_lch_rdy),
        .x_src_vld     (x_src_vld),
        .create0_en    (create0_en),
        .create0_entry (create0_entry),
        .create1_en    (create1_en),
        .create1_entry (create1_entry),
        .lch_stall     (lch_stall),
        .lch_pop       (lch_pop),
        .lch_cancel    (lch_cancel),
        .lch_vld       (lch_vld),
        .lch_entry     (lch_entry),
        .frz           (frz)
    );

    initial y_clk = 1'b0;
    always #5 y_clk = ~y_clk;

    typedef struct {
        string                nm;
        logic                 rst;
        logic [ENTRY-1:0]     vld;
        logic [ENTRY*SRC-1:0] rdy;
        logic [ENTRY*SRC-1:0] sv;
        logic [ENTRY-1:0]     c0;
        logic [ENTRY-1:0]     c1;
        logic                 stall;
        logic [ENTRY-1:0]     pop;
        logic                 cancel;
        logic                 ev;
        logic [ENTRY-1:0]     ee;
        logic [ENTRY-1:0]     ef;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;
    logic [ENTRY*SRC-1:0] rdy_d = '1;
    logic [ENTRY*SRC-1:0] sv_d  = '1;

    // One cycle: inputs applied before the edge, expected outputs after it.
    function automatic vec_t mk(string nm, logic rst, logic [7:0] vld,
                                logic [7:0] c0, logic [7:0] c1, logic stall,
                                logic [7:0] pop, logic cancel,
                                logic ev, logic [7:0] ee, logic [7:0] ef);
        vec_t v;
        v.nm = nm; v.rst = rst; v.vld = vld; v.rdy = rdy_d; v.sv = sv_d;
        v.c0 = c0; v.c1 = c1; v.stall = stall; v.pop = pop; v.cancel = cancel;
        v.ev = ev; v.ee = ee; v.ef = ef;
        return v;
    endfunction

    task automatic step(input vec_t v);
        cpurst        = v.rst;
        x_vld         = v.vld;
        x_lch_rdy     = v.rdy;
        x_src_vld     = v.sv;
        create0_en    = (v.c0 != '0);
        create0_entry = v.c0;
        create1_en    = (v.c1 != '0);
        create1_entry = v.c1;
        lch_stall     = v.stall;
        lch_pop       = v.pop;
        lch_cancel    = v.cancel;
        if (!v.rst) begin
            if (create0_en)
                assert ($onehot(v.c0) && (v.c0 & v.vld) == '0)
                    else $error("illegal create0 at %s", v.nm);
            if (create1_en)
                assert ($onehot(v.c1) && (v.c1 & v.vld) == '0 && v.c1 != v.c0)
                    else $error("illegal create1 at %s", v.nm);
            assert ($onehot0(v.pop) && (v.pop & ~frz) == '0)
                else $error("illegal pop at %s", v.nm);
        end
        @(posedge y_clk);
        #1;
        total++;
        if (lch_vld !== v.ev) begin
            bad++;
            $display("FAIL %s lch_vld got=%0b exp=%0b", v.nm, lch_vld, v.ev);
        end
        total++;
        if (lch_entry !== v.ee) begin
            bad++;
            $display("FAIL %s lch_entry got=%02h exp=%02h", v.nm, lch_entry, v.ee);
        end
        total++;
        if (frz !== v.ef) begin
            bad++;
            $display("FAIL %s frz got=%02h exp=%02h", v.nm, frz, v.ef);
        end
    endtask

    initial begin
        cpurst = 1'b1; x_vld = '0; x_lch_rdy = '1; x_src_vld = '1;
        create0_en = 1'b0; create0_entry = '0; create1_en = 1'b0; create1_entry = '0;
        lch_stall = 1'b0; lch_pop = '0; lch_cancel = 1'b0;

        //                nm          rst vld    c0     c1    stl pop   can  ev ee     ef
        // in-order create of 0,1,2
        vq.push_back(mk("rst0",       1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s1_cr0",     0, 8'h00, 8'h01, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s1_cr1",     0, 8'h01, 8'h02, 8'h00, 0, 8'h00, 0, 1, 8'h01, 8'h01));
        vq.push_back(mk("s1_cr2",     0, 8'h03, 8'h04, 8'h00, 0, 8'h00, 0, 1, 8'h02, 8'h03));
        vq.push_back(mk("s1_g2",      0, 8'h07, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h04, 8'h07));
        vq.push_back(mk("s1_idle",    0, 8'h07, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h07));
        // dual create: 5 (port0) older than 2 (port1)
        vq.push_back(mk("rst1",       1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s2_cr",      0, 8'h00, 8'h20, 8'h04, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s2_g5",      0, 8'h24, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h20, 8'h20));
        vq.push_back(mk("s2_g2",      0, 8'h24, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h04, 8'h24));
        vq.push_back(mk("s2_idle",    0, 8'h24, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h24));
        // oldest entry 1 waits on a source, younger 6 goes first
        vq.push_back(mk("rst2",       1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s3_cr1",     0, 8'h00, 8'h02, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        rdy_d = 24'hFFFFDF;
        vq.push_back(mk("s3_cr6",     0, 8'h02, 8'h40, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s3_g6",      0, 8'h42, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h40, 8'h40));
        rdy_d = '1;
        vq.push_back(mk("s3_g1",      0, 8'h42, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h02, 8'h42));
        // stall for three cycles; entry 0 has an unused, not-ready source
        vq.push_back(mk("rst3",       1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s4_cr0",     0, 8'h00, 8'h01, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        rdy_d = 24'hFFFFFE; sv_d = 24'hFFFFFE;
        vq.push_back(mk("s4_st1",     0, 8'h01, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s4_st2",     0, 8'h01, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s4_st3",     0, 8'h01, 8'h00, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s4_go",      0, 8'h01, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h01, 8'h01));
        vq.push_back(mk("s4_idle",    0, 8'h01, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h01));
        rdy_d = '1; sv_d = '1;
        // cancel regrants entry 3, pop retires it
        vq.push_back(mk("rst4",       1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s5_cr3",     0, 8'h00, 8'h08, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s5_g3",      0, 8'h08, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h08, 8'h08));
        vq.push_back(mk("s5_cancel",  0, 8'h08, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00));
        vq.push_back(mk("s5_regrant", 0, 8'h08, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h08, 8'h08));
        vq.push_back(mk("s5_pop",     0, 8'h08, 8'h00, 8'h00, 0, 8'h08, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s5_gone",    0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        // grant in the same cycle as a cancel keeps its new freeze
        vq.push_back(mk("rst5",       1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s6_cr",      0, 8'h00, 8'h01, 8'h02, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        vq.push_back(mk("s6_g0",      0, 8'h03, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h01, 8'h01));
        vq.push_back(mk("s6_g1_can",  0, 8'h03, 8'h00, 8'h00, 0, 8'h00, 1, 1, 8'h02, 8'h02));
        vq.push_back(mk("s6_g0_again",0, 8'h03, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h01, 8'h03));
        vq.push_back(mk("rst6",       1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));

        for (int k = 0; k < vq.size(); k++) step(vq[k]);

        // Reset in the middle of a launch burst while entry 4 is ready.
        step(mk("r_cr01",    0, 8'h00, 8'h01, 8'h02, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        step(mk("r_cr23",    0, 8'h03, 8'h04, 8'h08, 0, 8'h00, 0, 1, 8'h01, 8'h01));
        step(mk("r_cr4",     0, 8'h0F, 8'h10, 8'h00, 0, 8'h00, 0, 1, 8'h02, 8'h03));
        step(mk("r_g2",      0, 8'h1F, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h04, 8'h07));
        step(mk("r_g3",      0, 8'h1F, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h08, 8'h0F));
        step(mk("r_rst",     1, 8'h1F, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        step(mk("r_cr64",    0, 8'h00, 8'h40, 8'h10, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        step(mk("r_g6",      0, 8'h50, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h40, 8'h40));
        step(mk("r_g4",      0, 8'h50, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h10, 8'h50));
        // re-creating a frozen slot unfreezes it, then it launches again
        step(mk("r_recr6",   0, 8'h00, 8'h40, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h10));
        step(mk("r_g6b",     0, 8'h40, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h40, 8'h50));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
